// File: rtl/rr_packet_arbiter.sv
// ---------------------------------------------------------------------------
// rr_packet_arbiter
//
// Output-port arbiter for one NoC switch output. PORTS_NUM neighbour receivers
// plus the local receiver (REQ_NUM = PORTS_NUM+1 requesters, at most 16)
// compete for a single downstream FIFO. Selection is round-robin, and the
// winner keeps the output locked until its last flit (flit bit ADDR_SIZE set)
// has been written.
//
// Flit layout (BUS_SIZE bits): [BUS_SIZE-1 : ADDR_SIZE+1] payload,
// [ADDR_SIZE] last-flit flag, [ADDR_SIZE-1:0] address.
//
// Ports:
//   clk       - clock, all state on the rising edge
//   a_rst     - asynchronous, active-low reset
//   req       - per-port flit valid, bit i = port i presents a flit
//   data_i    - flat flit bus, port i at [i*BUS_SIZE +: BUS_SIZE]
//   is_full   - downstream FIFO full; no write is issued while high
//   grant     - registered one-hot pulse: that port's flit was taken
//   wr_req    - registered FIFO write strobe, coincident with grant
//   data_o    - registered flit to the FIFO, holds its value between writes
//   busy      - a port currently owns the output
//   cur_port  - index of the owning port, meaningful while busy=1
//   wdog_evt  - (ARB_WATCHDOG_EN only) one-cycle pulse when a stalled
//               packet lock is released by the watchdog
//
// Build option: define ARB_WATCHDOG_EN to add the stall watchdog. Without it
// a lock waits indefinitely for the owning port.
//
// Timing: IDLE arbitrates in one cycle, XFER accepts a flit, HOLD gives the
// requester one cycle to advance its flit so the same flit is never accepted
// twice. Peak rate is one flit every two cycles.
// ---------------------------------------------------------------------------
module rr_packet_arbiter #(
    parameter int DATA_SIZE   = 32,
    parameter int ADDR_SIZE   = 4,
    parameter int PORTS_NUM   = 4,
    parameter int BUS_SIZE    = DATA_SIZE + ADDR_SIZE + 1,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              a_rst,
    input  logic [PORTS_NUM:0]                req,
    input  logic [(PORTS_NUM+1)*BUS_SIZE-1:0] data_i,
    input  logic                              is_full,
    output logic [PORTS_NUM:0]                grant,
    output logic                              wr_req,
    output logic [BUS_SIZE-1:0]               data_o,
    output logic                              busy,
`ifdef ARB_WATCHDOG_EN
    output logic                              wdog_evt,
`endif
    output logic [3:0]                        cur_port
);

    localparam int REQ_NUM = PORTS_NUM + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Configurations outside the supported range (more than 16 requesters,
    // watchdog limit below 2) land here; the block is intentionally empty so
    // a misconfiguration shows up as this named scope in the elaborated tree.
    if (REQ_NUM > 16 || WDOG_CYCLES < 2) begin : g_unsupported_config
    end

    // -----------------------------------------------------------------------
    // Requests and flit slices widened to 16 entries so that the 4-bit port
    // index addresses them without width adaptation; unused entries read 0.
    // -----------------------------------------------------------------------
    logic [15:0]         req_ext;
    logic [BUS_SIZE-1:0] slice_arr [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_slice
        if (gi < REQ_NUM) begin : g_used
            assign req_ext[gi]   = req[gi];
            assign slice_arr[gi] = data_i[gi*BUS_SIZE +: BUS_SIZE];
        end else begin : g_unused
            assign req_ext[gi]   = 1'b0;
            assign slice_arr[gi] = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [3:0]          ptr_q,      ptr_d;
    logic [3:0]          cur_port_q, cur_port_d;
    logic                busy_q,     busy_d;
    logic [REQ_NUM-1:0]  grant_q,    grant_d;
    logic                wr_req_q,   wr_req_d;
    logic [BUS_SIZE-1:0] data_o_q,   data_o_d;

`ifdef ARB_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0]   wdog_cnt_q, wdog_cnt_d;
    logic                wdog_evt_q, wdog_evt_d;
`endif

    // -----------------------------------------------------------------------
    // Round-robin search: first requester after ptr_q, wrapping modulo
    // REQ_NUM. ptr_q itself is checked last, so the previous owner has the
    // lowest priority in the next round.
    // -----------------------------------------------------------------------
    logic       win_found;
    logic [3:0] win_idx;

    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 1; k <= REQ_NUM; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= REQ_NUM) begin
                cand = cand - REQ_NUM;
            end
            if (!win_found && req_ext[cand[3:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[3:0];
            end
        end
    end

    // One-hot decode of the owning port, trimmed to the requester count.
    logic [15:0] owner_onehot;
    assign owner_onehot = 16'd1 << cur_port_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_port_d = cur_port_q;
        busy_d     = busy_q;
        grant_d    = '0;
        wr_req_d   = 1'b0;
        data_o_d   = data_o_q;
`ifdef ARB_WATCHDOG_EN
        // Any path that does not explicitly keep or advance the counter
        // clears it, which covers transfers and every state change.
        wdog_cnt_d = '0;
        wdog_evt_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                // win_found implies at least one request is pending.
                if (!is_full && win_found) begin
                    cur_port_d = win_idx;
                    busy_d     = 1'b1;
                    state_d    = ST_XFER;
                end
            end

            ST_XFER: begin
                // The lock is held regardless of other requesters; only the
                // owner's request is considered here.
                if (req_ext[cur_port_q] && !is_full) begin
                    grant_d  = owner_onehot[REQ_NUM-1:0];
                    wr_req_d = 1'b1;
                    data_o_d = slice_arr[cur_port_q];
                    state_d  = ST_HOLD;
                end
`ifdef ARB_WATCHDOG_EN
                else if (!req_ext[cur_port_q] && !is_full) begin
                    // Owner went silent while the FIFO could accept data.
                    if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                        ptr_d      = cur_port_q;
                        busy_d     = 1'b0;
                        wdog_evt_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        wdog_cnt_d = wdog_cnt_q + 1'b1;
                    end
                end else begin
                    // FIFO back-pressure: neither a stall nor a transfer,
                    // so the count is frozen.
                    wdog_cnt_d = wdog_cnt_q;
                end
`endif
            end

            ST_HOLD: begin
                // data_o_q is the flit written on the previous edge, so its
                // last-flit flag decides whether the lock is released.
                if (data_o_q[ADDR_SIZE]) begin
                    ptr_d   = cur_port_q;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_XFER;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 4'(PORTS_NUM);
            cur_port_q <= '0;
            busy_q     <= 1'b0;
            grant_q    <= '0;
            wr_req_q   <= 1'b0;
            data_o_q   <= '0;
`ifdef ARB_WATCHDOG_EN
            wdog_cnt_q <= '0;
            wdog_evt_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_port_q <= cur_port_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            wr_req_q   <= wr_req_d;
            data_o_q   <= data_o_d;
`ifdef ARB_WATCHDOG_EN
            wdog_cnt_q <= wdog_cnt_d;
            wdog_evt_q <= wdog_evt_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign wr_req   = wr_req_q;
    assign data_o   = data_o_q;
    assign busy     = busy_q;
    assign cur_port = cur_port_q;
`ifdef ARB_WATCHDOG_EN
    assign wdog_evt = wdog_evt_q;
`endif

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_packet_arbiter
//
// Bench for rr_packet_arbiter with default parameters (5 requesters,
// 37-bit flits). Phases:
//   1. reset held with random inputs, outputs must stay 0
//   2. table of per-cycle vectors: single flit, round-robin, back-pressure,
//      all-ports rotation with wrap
//   3. hand-written sequences: packet lock, 5-cycle FIFO stall inside a
//      packet, asynchronous reset in the middle of XFER
//   4. random packets / request gaps / FIFO stalls against a scoreboard that
//      knows only the arbitration rules (who may win, lock until last flit,
//      no write while full)
// ---------------------------------------------------------------------------
module tb_rr_packet_arbiter;

    localparam int N  = 5;
    localparam int BW = 37;

    logic              clk;
    logic              a_rst;
    logic [N-1:0]      req;
    logic [N*BW-1:0]   data_i;
    logic              is_full;
    logic [N-1:0]      grant;
    logic              wr_req;
    logic [BW-1:0]     data_o;
    logic              busy;
    logic [3:0]        cur_port;
`ifdef ARB_WATCHDOG_EN
    logic              wdog_evt;
`endif

    rr_packet_arbiter dut (
        .clk      (clk),
        .a_rst    (a_rst),
        .req      (req),
        .data_i   (data_i),
        .is_full  (is_full),
        .grant    (grant),
        .wr_req   (wr_req),
        .data_o   (data_o),
        .busy     (busy),
`ifdef ARB_WATCHDOG_EN
        .wdog_evt (wdog_evt),
`endif
        .cur_port (cur_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int edge_no = 0;

    // Per-port flit sources: req follows "queue not empty and not held off".
    logic [BW-1:0] fq [N][$];
    logic [N-1:0]  hold_off;

    typedef struct {
        int            e;
        int            p;
        logic [BW-1:0] d;
    } glog_t;
    glog_t glog[$];

    typedef struct {
        logic [N-1:0]  req;
        logic          full;
        logic [N-1:0]  g;
        logic          wr;
        logic [BW-1:0] d;
        logic          b;
        logic [3:0]    c;
    } vec_t;
    vec_t tbl[31];

    function automatic logic [BW-1:0] mk(input int p, input logic last, input logic [31:0] pay);
        return {pay, last, 4'(p)};
    endfunction

    function automatic logic [BW-1:0] tf(input int p);
        return mk(p, 1'b1, 32'hA5A5_A500 + 32'(p));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (fq[i].size() != 0) && !hold_off[i];
            data_i[i*BW +: BW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        a_rst    = 1'b0;
        req      = '0;
        data_i   = '0;
        is_full  = 1'b0;
        hold_off = '0;
        for (int i = 0; i < N; i++) fq[i].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_rst   = 1'b1;
        edge_no = 0;
    endtask

    // Run n edges from the flit queues; is_full before edge e is full_mask[e].
    // Every grant is logged and its data checked against the queue head.
    task automatic run_seq(input string tag, input int n, input logic [63:0] full_mask);
        int p;
        glog.delete();
        for (int e = 1; e <= n; e++) begin
            drive();
            is_full = full_mask[e];
            tick();
            check({tag, "_wr"}, wr_req, (grant != '0));
            if (grant != '0) begin
                p = onehot_idx(grant);
                glog.push_back('{edge_no, p, data_o});
                $display("%s edge=%0d grant port %0d data=%h", tag, edge_no, p, data_o);
                if (p >= 0 && fq[p].size() != 0) begin
                    check({tag, "_data"}, data_o, fq[p][0]);
                    void'(fq[p].pop_front());
                end
            end
        end
    endtask

    task automatic check_glog(input string tag, input int idx, input int exp_e, input int exp_p);
        if (idx < glog.size()) begin
            check({tag, "_gedge"}, 64'(glog[idx].e), 64'(exp_e));
            check({tag, "_gport"}, 64'(glog[idx].p), 64'(exp_p));
        end else begin
            check({tag, "_gmissing"}, 64'(glog.size()), 64'(idx + 1));
        end
    endtask

    // -----------------------------------------------------------------------
    // Random phase: scoreboard built from the arbitration rules only.
    // -----------------------------------------------------------------------
    task automatic random_test();
        int            remaining;
        int            last_owner;
        int            sel;
        int            p, q, exp_w, cyc;
        logic          busy_prev, full_at, release_pend;
        logic [N-1:0]  req_at;
        logic [BW-1:0] last_data;
        logic [31:0]   pay;
        int            len, port;

        do_reset();
        remaining = 0;
        for (int k = 0; k < 40; k++) begin
            port = $urandom_range(N-1);
            len  = $urandom_range(3, 1);
            for (int f = 0; f < len; f++) begin
                pay = $urandom;
                fq[port].push_back(mk(port, (f == len-1), pay));
                remaining++;
            end
        end

        last_owner   = N - 1;   // reset pointer: port 0 searched first
        sel          = -1;
        busy_prev    = 1'b0;
        release_pend = 1'b0;
        last_data    = '0;
        cyc          = 0;

        while (remaining > 0 && cyc < 4000) begin
            for (int i = 0; i < N; i++) hold_off[i] = ($urandom_range(3) == 0);
            drive();
            is_full = ($urandom_range(9) < 3);
            req_at  = req;
            full_at = is_full;
            tick();
            cyc++;

            check("rnd_onehot", $onehot0(grant), 1);
            check("rnd_wr", wr_req, (grant != '0));

            if (release_pend) begin
                check("rnd_release", busy, 1'b0);
                release_pend = 1'b0;
            end

            if (!busy_prev) begin
                // From an unlocked output, arbitration must happen exactly
                // when someone requests and the FIFO has room.
                check("rnd_arb_take", busy, (!full_at && req_at != '0));
                if (busy) begin
                    exp_w = -1;
                    for (int k = 1; k <= N; k++) begin
                        q = (last_owner + k) % N;
                        if (exp_w < 0 && req_at[q]) exp_w = q;
                    end
                    check("rnd_arb_winner", 64'(cur_port), 64'(exp_w));
                    sel = exp_w;
                end
            end

            if (grant != '0) begin
                p = onehot_idx(grant);
                $display("rnd edge=%0d grant port %0d data=%h", edge_no, p, data_o);
                check("rnd_lock", 64'(p), 64'(sel));
                check("rnd_full_write", full_at, 1'b0);
                check("rnd_req_write", req_at[p], 1'b1);
                if (fq[p].size() != 0) begin
                    check("rnd_data", data_o, fq[p][0]);
                    if (fq[p][0][4]) begin
                        last_owner   = p;
                        sel          = -1;
                        release_pend = 1'b1;
                    end
                    void'(fq[p].pop_front());
                    remaining--;
                end
                last_data = data_o;
            end else begin
                check("rnd_data_hold", data_o, last_data);
            end
            busy_prev = busy;
        end
        check("rnd_drain", 64'(remaining), 64'd0);
        hold_off = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // --------------------------------------------------------------
        // Expected per-cycle behaviour from reset (pointer starts at 4).
        // --------------------------------------------------------------
        tbl[0]  = '{5'b00100, 1'b0, 5'b00000, 1'b0, '0,     1'b1, 4'd2};
        tbl[1]  = '{5'b00100, 1'b0, 5'b00100, 1'b1, tf(2), 1'b1, 4'd2};
        tbl[2]  = '{5'b00000, 1'b0, 5'b00000, 1'b0, tf(2), 1'b0, 4'd0};
        tbl[3]  = '{5'b01001, 1'b0, 5'b00000, 1'b0, tf(2), 1'b1, 4'd3};
        tbl[4]  = '{5'b01001, 1'b0, 5'b01000, 1'b1, tf(3), 1'b1, 4'd3};
        tbl[5]  = '{5'b01001, 1'b0, 5'b00000, 1'b0, tf(3), 1'b0, 4'd0};
        tbl[6]  = '{5'b01001, 1'b0, 5'b00000, 1'b0, tf(3), 1'b1, 4'd0};
        tbl[7]  = '{5'b01001, 1'b0, 5'b00001, 1'b1, tf(0), 1'b1, 4'd0};
        tbl[8]  = '{5'b01001, 1'b0, 5'b00000, 1'b0, tf(0), 1'b0, 4'd0};
        tbl[9]  = '{5'b01001, 1'b0, 5'b00000, 1'b0, tf(0), 1'b1, 4'd3};
        tbl[10] = '{5'b01001, 1'b0, 5'b01000, 1'b1, tf(3), 1'b1, 4'd3};
        tbl[11] = '{5'b01001, 1'b0, 5'b00000, 1'b0, tf(3), 1'b0, 4'd0};
        tbl[12] = '{5'b00001, 1'b1, 5'b00000, 1'b0, tf(3), 1'b0, 4'd0};
        tbl[13] = '{5'b00001, 1'b0, 5'b00000, 1'b0, tf(3), 1'b1, 4'd0};
        tbl[14] = '{5'b00001, 1'b1, 5'b00000, 1'b0, tf(3), 1'b1, 4'd0};
        tbl[15] = '{5'b00001, 1'b0, 5'b00001, 1'b1, tf(0), 1'b1, 4'd0};
        tbl[16] = '{5'b00001, 1'b0, 5'b00000, 1'b0, tf(0), 1'b0, 4'd0};
        tbl[17] = '{5'b11111, 1'b0, 5'b00000, 1'b0, tf(0), 1'b1, 4'd1};
        tbl[18] = '{5'b11111, 1'b0, 5'b00010, 1'b1, tf(1), 1'b1, 4'd1};
        tbl[19] = '{5'b11111, 1'b0, 5'b00000, 1'b0, tf(1), 1'b0, 4'd0};
        tbl[20] = '{5'b11111, 1'b0, 5'b00000, 1'b0, tf(1), 1'b1, 4'd2};
        tbl[21] = '{5'b11111, 1'b0, 5'b00100, 1'b1, tf(2), 1'b1, 4'd2};
        tbl[22] = '{5'b11111, 1'b0, 5'b00000, 1'b0, tf(2), 1'b0, 4'd0};
        tbl[23] = '{5'b11111, 1'b0, 5'b00000, 1'b0, tf(2), 1'b1, 4'd3};
        tbl[24] = '{5'b11111, 1'b0, 5'b01000, 1'b1, tf(3), 1'b1, 4'd3};
        tbl[25] = '{5'b11111, 1'b0, 5'b00000, 1'b0, tf(3), 1'b0, 4'd0};
        tbl[26] = '{5'b11111, 1'b0, 5'b00000, 1'b0, tf(3), 1'b1, 4'd4};
        tbl[27] = '{5'b11111, 1'b0, 5'b10000, 1'b1, tf(4), 1'b1, 4'd4};
        tbl[28] = '{5'b11111, 1'b0, 5'b00000, 1'b0, tf(4), 1'b0, 4'd0};
        tbl[29] = '{5'b11111, 1'b0, 5'b00000, 1'b0, tf(4), 1'b1, 4'd0};
        tbl[30] = '{5'b11111, 1'b0, 5'b00001, 1'b1, tf(0), 1'b1, 4'd0};

        // ---------------- reset with random inputs ----------------------
        a_rst    = 1'b0;
        hold_off = '0;
        is_full  = 1'b0;
        req      = '0;
        data_i   = '0;
        for (int c = 0; c < 3; c++) begin
            req     = N'($urandom);
            is_full = 1'($urandom);
            for (int i = 0; i < N; i++) data_i[i*BW +: BW] = mk(i, 1'($urandom), $urandom);
            tick();
            check("rst_grant", grant, '0);
            check("rst_wr", wr_req, 1'b0);
            check("rst_data", data_o, '0);
            check("rst_busy", busy, 1'b0);
            check("rst_cur", cur_port, 4'd0);
            $display("reset cycle %0d req=%b busy=%b", c, req, busy);
        end
        @(negedge clk);
        a_rst   = 1'b1;
        edge_no = 0;

        // ---------------- table-driven vectors --------------------------
        for (int i = 0; i < N; i++) data_i[i*BW +: BW] = tf(i);
        for (int k = 0; k < 31; k++) begin
            req     = tbl[k].req;
            is_full = tbl[k].full;
            tick();
            check("tbl_grant", grant, tbl[k].g);
            check("tbl_wr", wr_req, tbl[k].wr);
            check("tbl_data", data_o, tbl[k].d);
            check("tbl_busy", busy, tbl[k].b);
            if (tbl[k].b) check("tbl_cur", cur_port, tbl[k].c);
            $display("vec %0d req=%b full=%b -> grant=%b wr=%b busy=%b cur=%0d",
                     k, req, is_full, grant, wr_req, busy, cur_port);
        end

        // ---------------- packet lock: port 1 three flits, port 4 waits --
        do_reset();
        fq[1].push_back(mk(1, 1'b0, 32'h1111_0001));
        fq[1].push_back(mk(1, 1'b0, 32'h1111_0002));
        fq[1].push_back(mk(1, 1'b1, 32'h1111_0003));
        fq[4].push_back(mk(4, 1'b1, 32'h4444_0001));
        run_seq("lock", 11, 64'd0);
        check("lock_count", 64'(glog.size()), 64'd4);
        check_glog("lock", 0, 2, 1);
        check_glog("lock", 1, 4, 1);
        check_glog("lock", 2, 6, 1);
        check_glog("lock", 3, 9, 4);

        // ---------------- back-pressure inside a 2-flit packet ----------
        do_reset();
        fq[0].push_back(mk(0, 1'b0, 32'h0B0B_0001));
        fq[0].push_back(mk(0, 1'b1, 32'h0B0B_0002));
        run_seq("bp", 11, 64'h1F0);   // is_full before edges 4..8
        check("bp_count", 64'(glog.size()), 64'd2);
        check_glog("bp", 0, 2, 0);
        check_glog("bp", 1, 9, 0);

        // ---------------- asynchronous reset during XFER -----------------
        do_reset();
        fq[2].push_back(mk(2, 1'b0, 32'hA5A5_A5A5));
        fq[2].push_back(mk(2, 1'b1, 32'h5A5A_5A5A));
        run_seq("arst", 5, 64'hFF0);  // flit 1 written, then stalled in XFER
        check("arst_pre_busy", busy, 1'b1);
        check("arst_pre_cur", cur_port, 4'd2);
        #2;
        a_rst = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_cur", cur_port, 4'd0);
        check("arst_data", data_o, '0);
        check("arst_wr", wr_req, 1'b0);
        check("arst_grant", grant, '0);
        $display("async reset mid-XFER busy=%b data=%h", busy, data_o);

        // ---------------- random packets vs scoreboard -------------------
        random_test();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
